// File: rtl/register_file_v2.sv
// Multi-ported register file with write-first bypass and per-register
// writeback-pending (busy) tracking plus a live busy population count.
module register_file_v2 #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned AW       = 5,
  parameter bit          ZERO_REG = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   rs1,
  input  logic [AW-1:0]   rs2,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  output logic            rs1_busy,
  output logic            rs2_busy,
  input  logic            wr0_en,
  input  logic [AW-1:0]   wr0_addr,
  input  logic [XLEN-1:0] wr0_data,
  input  logic            wr1_en,
  input  logic [AW-1:0]   wr1_addr,
  input  logic [XLEN-1:0] wr1_data,
  input  logic            busy_set_en,
  input  logic [AW-1:0]   busy_set_addr,
  output logic [AW:0]     busy_cnt
);

  localparam int unsigned NREG = 2 ** AW;
  localparam int unsigned CW   = AW + 1;

  logic [XLEN-1:0] regs [NREG];
  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;
  logic [CW-1:0]   cnt_d;
  logic            wr0_ok;
  logic            wr1_ok;
  logic            set_ok;

  // Address 0 is a sink for writes and busy marks when it is hardwired.
  assign wr0_ok = wr0_en && !(ZERO_REG && (wr0_addr == '0));
  assign wr1_ok = wr1_en && !(ZERO_REG && (wr1_addr == '0));
  assign set_ok = busy_set_en && !(ZERO_REG && (busy_set_addr == '0));

  // Read value for one port: stored data overridden by same-cycle writes, wr1 last.
  function automatic logic [XLEN-1:0] read_port(
    input logic [AW-1:0]   a,
    input logic [XLEN-1:0] stored,
    input logic            w0_ok,
    input logic [AW-1:0]   w0_addr,
    input logic [XLEN-1:0] w0_data,
    input logic            w1_ok,
    input logic [AW-1:0]   w1_addr,
    input logic [XLEN-1:0] w1_data
  );
    logic [XLEN-1:0] v;
    v = stored;
    if (w0_ok && (w0_addr == a)) v = w0_data;
    if (w1_ok && (w1_addr == a)) v = w1_data;
    if (ZERO_REG && (a == '0))   v = '0;
    return v;
  endfunction

  // Combinational read ports; the bypass is suppressed while reset is held.
  assign rs1_data = rst ? '0 : read_port(rs1, regs[rs1], wr0_ok, wr0_addr, wr0_data,
                                         wr1_ok, wr1_addr, wr1_data);
  assign rs2_data = rst ? '0 : read_port(rs2, regs[rs2], wr0_ok, wr0_addr, wr0_data,
                                         wr1_ok, wr1_addr, wr1_data);

  // Busy flags come straight from the registered bits.
  assign rs1_busy = busy_q[rs1];
  assign rs2_busy = busy_q[rs2];

  // Storage update; wr1 is applied after wr0 so it wins on a shared address.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs[AW'(i)] <= '0;
    end else begin
      if (wr0_ok) regs[wr0_addr] <= wr0_data;
      if (wr1_ok) regs[wr1_addr] <= wr1_data;
    end
  end

  // Next busy vector: writebacks clear, a new producer set is applied last so it wins.
  always_comb begin
    busy_d = busy_q;
    if (wr0_en) busy_d[wr0_addr] = 1'b0;
    if (wr1_en) busy_d[wr1_addr] = 1'b0;
    if (set_ok) busy_d[busy_set_addr] = 1'b1;
  end

  // Population count of the next busy vector so the count tracks the bits exactly.
  always_comb begin
    cnt_d = '0;
    for (int i = 0; i < NREG; i++) cnt_d = cnt_d + CW'(busy_d[AW'(i)]);
  end

  // Busy bits and their count share one register stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q   <= '0;
      busy_cnt <= '0;
    end else begin
      busy_q   <= busy_d;
      busy_cnt <= cnt_d;
    end
  end

endmodule

// File: tb/tb_register_file_v2.sv
// Bench for register_file_v2: directed scenarios with literal expectations plus
// a per-cycle comparison against an array-based reference model.
module tb_register_file_v2;

  localparam int unsigned XLEN = 32;
  localparam int unsigned AW   = 5;
  localparam int unsigned NREG = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic [AW-1:0]   rs1, rs2;
  logic [XLEN-1:0] rs1_data, rs2_data;
  logic            rs1_busy, rs2_busy;
  logic            wr0_en, wr1_en, busy_set_en;
  logic [AW-1:0]   wr0_addr, wr1_addr, busy_set_addr;
  logic [XLEN-1:0] wr0_data, wr1_data;
  logic [AW:0]     busy_cnt;

  int passed = 0;
  int total  = 0;

  logic [XLEN-1:0] m_reg  [NREG];
  bit              m_busy [NREG];

  register_file_v2 #(.XLEN(XLEN), .AW(AW), .ZERO_REG(1'b1)) dut (
    .clk(clk), .rst(rst),
    .rs1(rs1), .rs2(rs2),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
    .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
    .busy_set_en(busy_set_en), .busy_set_addr(busy_set_addr),
    .busy_cnt(busy_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    else passed++;
  endtask

  // Expected read value from the model and the current write inputs.
  function automatic logic [XLEN-1:0] exp_read(input logic [AW-1:0] a);
    if (rst || a == 0) return '0;
    if (wr1_en && wr1_addr == a) return wr1_data;
    if (wr0_en && wr0_addr == a) return wr0_data;
    return m_reg[a];
  endfunction

  function automatic int exp_cnt();
    int n = 0;
    foreach (m_busy[i]) if (m_busy[i]) n++;
    return n;
  endfunction

  initial begin
    foreach (m_reg[i]) begin m_reg[i] = '0; m_busy[i] = 1'b0; end
  end

  // Reference model: registers as an array, busy as a set of flags.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      foreach (m_reg[i]) begin m_reg[i] = '0; m_busy[i] = 1'b0; end
    end else begin
      if (wr0_en && wr0_addr != 0) m_reg[wr0_addr] = wr0_data;
      if (wr1_en && wr1_addr != 0) m_reg[wr1_addr] = wr1_data;
      if (wr0_en) m_busy[wr0_addr] = 1'b0;
      if (wr1_en) m_busy[wr1_addr] = 1'b0;
      if (busy_set_en && busy_set_addr != 0) m_busy[busy_set_addr] = 1'b1;
    end
  end

  // Every falling edge: all outputs against the model.
  always @(negedge clk) begin
    check("rs1_data", rs1_data, exp_read(rs1));
    check("rs2_data", rs2_data, exp_read(rs2));
    check("rs1_busy", 32'(rs1_busy), (rst || !m_busy[rs1]) ? 32'd0 : 32'd1);
    check("rs2_busy", 32'(rs2_busy), (rst || !m_busy[rs2]) ? 32'd0 : 32'd1);
    check("busy_cnt", 32'(busy_cnt), 32'(exp_cnt()));
  end

  task automatic idle();
    wr0_en = 0; wr0_addr = '0; wr0_data = '0;
    wr1_en = 0; wr1_addr = '0; wr1_data = '0;
    busy_set_en = 0; busy_set_addr = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; rs1 = '0; rs2 = '0;
    idle();
    repeat (2) step();
    check("reset_cnt", 32'(busy_cnt), 32'd0);
    check("reset_rd", rs1_data, 32'd0);
    rst = 1'b0;

    // Writes to register 0 are discarded and never bypassed.
    wr0_en = 1; wr0_addr = 5'd0; wr0_data = 32'hDEADBEEF; rs1 = 5'd0;
    #1 check("zero_bypass", rs1_data, 32'd0);
    step(); idle();
    #1 check("zero_read", rs1_data, 32'd0);
    check("zero_cnt", 32'(busy_cnt), 32'd0);

    // Same-address dual write: wr1 wins, visible in the same cycle.
    wr0_en = 1; wr0_addr = 5'd5; wr0_data = 32'hCAFEBABE;
    wr1_en = 1; wr1_addr = 5'd5; wr1_data = 32'h12345678; rs1 = 5'd5;
    #1 check("dual_bypass", rs1_data, 32'h12345678);
    step(); idle();
    #1 check("dual_stored", rs1_data, 32'h12345678);

    // Busy accumulation, repeated set, and clear by writeback.
    busy_set_en = 1; busy_set_addr = 5'd3; step();
    check("cnt_after_3", 32'(busy_cnt), 32'd1);
    busy_set_addr = 5'd7; step();
    check("cnt_after_7", 32'(busy_cnt), 32'd2);
    busy_set_addr = 5'd3; step();
    check("cnt_reset_3", 32'(busy_cnt), 32'd2);
    idle(); rs1 = 5'd7;
    #1 check("busy7", 32'(rs1_busy), 32'd1);
    wr0_en = 1; wr0_addr = 5'd7; wr0_data = 32'h77;
    #1 check("busy7_no_bypass", 32'(rs1_busy), 32'd1);
    step(); idle();
    #1 check("cnt_after_wb7", 32'(busy_cnt), 32'd1);
    check("busy7_clear", 32'(rs1_busy), 32'd0);

    // Set and write on the same register: set wins, data still stored.
    busy_set_en = 1; busy_set_addr = 5'd9;
    wr1_en = 1; wr1_addr = 5'd9; wr1_data = 32'hA5A5A5A5; rs1 = 5'd9;
    #1 check("busy9_pre", 32'(rs1_busy), 32'd0);
    step(); idle();
    #1 check("busy9_set", 32'(rs1_busy), 32'd1);
    check("data9", rs1_data, 32'hA5A5A5A5);
    check("cnt_inc9", 32'(busy_cnt), 32'd2);

    // Net -2 then net -1 count changes.
    wr0_en = 1; wr0_addr = 5'd3; wr1_en = 1; wr1_addr = 5'd9; step(); idle();
    check("cnt_minus2", 32'(busy_cnt), 32'd0);
    busy_set_en = 1; busy_set_addr = 5'd1; step();
    busy_set_addr = 5'd2; step();
    check("cnt_1_2", 32'(busy_cnt), 32'd2);
    wr0_en = 1; wr0_addr = 5'd1; wr0_data = 32'h11;
    wr1_en = 1; wr1_addr = 5'd2; wr1_data = 32'h22;
    busy_set_addr = 5'd6; step(); idle();
    rs1 = 5'd6; rs2 = 5'd1;
    #1 check("cnt_net", 32'(busy_cnt), 32'd1);
    check("busy6", 32'(rs1_busy), 32'd1);
    check("busy1_clr", 32'(rs2_busy), 32'd0);
    rs2 = 5'd2;
    #1 check("busy2_clr", 32'(rs2_busy), 32'd0);

    // Busy set on register 0 is ignored.
    busy_set_en = 1; busy_set_addr = 5'd0; step(); idle();
    check("cnt_zero_set", 32'(busy_cnt), 32'd1);

    // Asynchronous reset between edges clears everything at once.
    wr0_en = 1; wr0_addr = 5'd5; wr0_data = 32'h55;
    wr1_en = 1; wr1_addr = 5'd10; wr1_data = 32'hAA;
    busy_set_en = 1; busy_set_addr = 5'd4; step(); idle();
    rs1 = 5'd5; rs2 = 5'd10;
    #1 check("pre_rst_5", rs1_data, 32'h55);
    check("pre_rst_10", rs2_data, 32'hAA);
    check("pre_rst_cnt", 32'(busy_cnt), 32'd2);
    rst = 1'b1;
    #1 check("rst_5", rs1_data, 32'd0);
    check("rst_10", rs2_data, 32'd0);
    check("rst_cnt", 32'(busy_cnt), 32'd0);
    wr0_en = 1; wr0_addr = 5'd5; wr0_data = 32'h99;
    busy_set_en = 1; busy_set_addr = 5'd8;
    #1 check("rst_no_bypass", rs1_data, 32'd0);
    step();
    check("rst_no_write", rs1_data, 32'd0);
    rst = 1'b0;
    step(); idle();
    #1 check("post_rst_write", rs1_data, 32'h99);
    check("post_rst_cnt", 32'(busy_cnt), 32'd1);

    // Mixed traffic on a narrow address range to force collisions.
    for (int i = 0; i < 300; i++) begin
      rs1 = AW'($urandom_range(0, 7)); rs2 = AW'($urandom_range(0, 7));
      wr0_en = 1'($urandom); wr0_addr = AW'($urandom_range(0, 7)); wr0_data = $urandom;
      wr1_en = 1'($urandom); wr1_addr = AW'($urandom_range(0, 7)); wr1_data = $urandom;
      busy_set_en = 1'($urandom); busy_set_addr = AW'($urandom_range(0, 7));
      step();
    end
    idle();
    step();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
